// File: rtl/ethernet_transmitter.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and a
// guaranteed inter-frame gap. Payload arrives on a valid/ready/last byte stream.
module ethernet_transmitter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ENABLE_CRC = 1,
    parameter int unsigned MIN_FRAME  = 60,
    parameter int unsigned IFG_BYTES  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_data_valid,
    input  logic                  tx_data_last,
    output logic                  tx_data_ready,
    output logic [DATA_WIDTH-1:0] txd,
    output logic                  tx_en,
    output logic                  tx_er,
    output logic                  tx_busy,
    output logic                  frame_sent,
    output logic                  frame_error,
    output logic [15:0]           frame_length
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_e;

    localparam logic        CrcOn     = (ENABLE_CRC != 0);
    localparam logic [15:0] MinFrameW = 16'(MIN_FRAME);
    // The IDLE cycle that samples tx_data_valid also drives tx_en=0, so the IFG
    // state itself lasts one cycle less than the visible gap.
    localparam int unsigned IfgStates = (IFG_BYTES > 1) ? IFG_BYTES - 1 : 1;
    localparam logic [15:0] IfgLast   = 16'(IfgStates - 1);
    localparam state_e      IfgEntry  = (IFG_BYTES > 1) ? StIfg : StIdle;

    // Reflected CRC-32, one byte LSB-first
    function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              pre_cnt_q, pre_cnt_d;
    logic [1:0]              fcs_cnt_q, fcs_cnt_d;
    logic [15:0]             ifg_cnt_q, ifg_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    abort_q, abort_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             tot_q, tot_d;
    logic [31:0]             crc_q, crc_d;
    logic                    sent_pend_q, sent_pend_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic                    tx_en_q, tx_en_d;
    logic                    tx_er_q, tx_er_d;
    logic                    frame_sent_q, frame_sent_d;
    logic                    frame_error_q, frame_error_d;
    logic [15:0]             frame_length_q, frame_length_d;
    logic                    accept;

    // Ready only while a payload byte can be taken: SFD cycle, or DATA before last/underrun
    assign tx_data_ready = (state_q == StSfd) ||
                           ((state_q == StData) && !last_q && !abort_q);
    assign tx_busy       = (state_q != StIdle);
    assign txd           = txd_q;
    assign tx_en         = tx_en_q;
    assign tx_er         = tx_er_q;
    assign frame_sent    = frame_sent_q;
    assign frame_error   = frame_error_q;
    assign frame_length  = frame_length_q;

    // Next-state and next-output logic; txd is driven one cycle behind the state
    always_comb begin
        state_d        = state_q;
        pre_cnt_d      = pre_cnt_q;
        fcs_cnt_d      = fcs_cnt_q;
        ifg_cnt_d      = '0;
        data_d         = data_q;
        last_d         = last_q;
        abort_d        = abort_q;
        len_d          = len_q;
        tot_d          = tot_q;
        crc_d          = crc_q;
        sent_pend_d    = 1'b0;
        txd_d          = '0;
        tx_en_d        = 1'b0;
        tx_er_d        = 1'b0;
        frame_sent_d   = sent_pend_q;
        frame_error_d  = 1'b0;
        frame_length_d = sent_pend_q ? len_q : frame_length_q;
        accept         = 1'b0;

        case (state_q)
            StIdle: begin
                if (tx_data_valid) begin
                    state_d   = StPreamble;
                    pre_cnt_d = '0;
                    fcs_cnt_d = '0;
                    crc_d     = '1;
                    len_d     = '0;
                    tot_d     = '0;
                    last_d    = 1'b0;
                    abort_d   = 1'b0;
                end
            end
            StPreamble: begin
                txd_d     = 8'h55;
                tx_en_d   = 1'b1;
                pre_cnt_d = pre_cnt_q + 3'd1;
                if (pre_cnt_q == 3'd6) begin
                    state_d = StSfd;
                end
            end
            StSfd: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                state_d = StData;
                if (tx_data_valid) begin
                    accept = 1'b1;
                end else begin
                    abort_d = 1'b1;
                end
            end
            StData: begin
                tx_en_d = 1'b1;
                if (abort_q) begin
                    // Underrun: one poisoned byte, no FCS
                    txd_d          = '0;
                    tx_er_d        = 1'b1;
                    frame_error_d  = 1'b1;
                    frame_length_d = len_q;
                    abort_d        = 1'b0;
                    state_d        = IfgEntry;
                end else begin
                    txd_d = data_q;
                    if (last_q) begin
                        last_d = 1'b0;
                        if (tot_q < MinFrameW) begin
                            state_d = StPad;
                        end else if (CrcOn) begin
                            state_d = StFcs;
                        end else begin
                            state_d     = IfgEntry;
                            sent_pend_d = 1'b1;
                        end
                    end else if (tx_data_valid) begin
                        accept = 1'b1;
                    end else begin
                        // Pending byte still goes out this cycle; error byte follows
                        abort_d = 1'b1;
                    end
                end
            end
            StPad: begin
                txd_d   = '0;
                tx_en_d = 1'b1;
                tot_d   = tot_q + 16'd1;
                if (CrcOn) begin
                    crc_d = crc_update(crc_q, 8'h00);
                end
                if ((tot_q + 16'd1) >= MinFrameW) begin
                    if (CrcOn) begin
                        state_d = StFcs;
                    end else begin
                        state_d     = IfgEntry;
                        sent_pend_d = 1'b1;
                    end
                end
            end
            StFcs: begin
                txd_d     = ~crc_q[{fcs_cnt_q, 3'b000} +: 8];
                tx_en_d   = 1'b1;
                fcs_cnt_d = fcs_cnt_q + 2'd1;
                if (fcs_cnt_q == 2'd3) begin
                    state_d     = IfgEntry;
                    sent_pend_d = 1'b1;
                end
            end
            StIfg: begin
                ifg_cnt_d = ifg_cnt_q + 16'd1;
                if (ifg_cnt_q == IfgLast) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            data_d = tx_data;
            last_d = tx_data_last;
            len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
            tot_d  = (tot_q == 16'hFFFF) ? tot_q : tot_q + 16'd1;
            if (CrcOn) begin
                crc_d = crc_update(crc_q, tx_data);
            end
        end
    end

    // State and registered GMII outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pre_cnt_q      <= '0;
            fcs_cnt_q      <= '0;
            ifg_cnt_q      <= '0;
            data_q         <= '0;
            last_q         <= 1'b0;
            abort_q        <= 1'b0;
            len_q          <= '0;
            tot_q          <= '0;
            crc_q          <= '1;
            sent_pend_q    <= 1'b0;
            txd_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            frame_sent_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            frame_length_q <= '0;
        end else begin
            state_q        <= state_d;
            pre_cnt_q      <= pre_cnt_d;
            fcs_cnt_q      <= fcs_cnt_d;
            ifg_cnt_q      <= ifg_cnt_d;
            data_q         <= data_d;
            last_q         <= last_d;
            abort_q        <= abort_d;
            len_q          <= len_d;
            tot_q          <= tot_d;
            crc_q          <= crc_d;
            sent_pend_q    <= sent_pend_d;
            txd_q          <= txd_d;
            tx_en_q        <= tx_en_d;
            tx_er_q        <= tx_er_d;
            frame_sent_q   <= frame_sent_d;
            frame_error_q  <= frame_error_d;
            frame_length_q <= frame_length_d;
        end
    end

endmodule

// File: tb/tb_ethernet_transmitter.sv
// Bench for ethernet_transmitter: three instances (default, no padding, no FCS)
// driven by a shared byte-stream driver and checked against a frame-level model.
module tb_ethernet_transmitter;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       rst_n;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       drv_last;
    int         sel;
    logic [2:0] vld;

    logic [7:0]  txd_a  [3];
    logic [15:0] flen_a [3];
    logic        rdy_a  [3];
    logic        en_a   [3];
    logic        er_a   [3];
    logic        busy_a [3];
    logic        sent_a [3];
    logic        ferr_a [3];

    assign vld = drv_valid ? 3'(1 << sel) : 3'b000;

    ethernet_transmitter #(.DATA_WIDTH(8), .ENABLE_CRC(1), .MIN_FRAME(60), .IFG_BYTES(12)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data), .tx_data_valid(vld[0]),
        .tx_data_last(drv_last), .tx_data_ready(rdy_a[0]), .txd(txd_a[0]), .tx_en(en_a[0]),
        .tx_er(er_a[0]), .tx_busy(busy_a[0]), .frame_sent(sent_a[0]),
        .frame_error(ferr_a[0]), .frame_length(flen_a[0])
    );
    ethernet_transmitter #(.DATA_WIDTH(8), .ENABLE_CRC(1), .MIN_FRAME(0), .IFG_BYTES(12)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data), .tx_data_valid(vld[1]),
        .tx_data_last(drv_last), .tx_data_ready(rdy_a[1]), .txd(txd_a[1]), .tx_en(en_a[1]),
        .tx_er(er_a[1]), .tx_busy(busy_a[1]), .frame_sent(sent_a[1]),
        .frame_error(ferr_a[1]), .frame_length(flen_a[1])
    );
    ethernet_transmitter #(.DATA_WIDTH(8), .ENABLE_CRC(0), .MIN_FRAME(60), .IFG_BYTES(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(drv_data), .tx_data_valid(vld[2]),
        .tx_data_last(drv_last), .tx_data_ready(rdy_a[2]), .txd(txd_a[2]), .tx_en(en_a[2]),
        .tx_er(er_a[2]), .tx_busy(busy_a[2]), .frame_sent(sent_a[2]),
        .frame_error(ferr_a[2]), .frame_length(flen_a[2])
    );

    logic [7:0]  m_txd;
    logic [15:0] m_flen;
    logic        m_rdy, m_en, m_er, m_busy, m_sent, m_err;
    assign m_txd  = txd_a[sel];
    assign m_flen = flen_a[sel];
    assign m_rdy  = rdy_a[sel];
    assign m_en   = en_a[sel];
    assign m_er   = er_a[sel];
    assign m_busy = busy_a[sel];
    assign m_sent = sent_a[sel];
    assign m_err  = ferr_a[sel];

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state for the selected instance
    int          cyc = 0;
    logic [7:0]  cap[$];
    bit          enh[$];
    int          sent_n, err_n, er_n, er_bad, rdy_idle, last_en_cyc, sent_cyc;
    logic [15:0] len_at;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample the selected DUT mid-cycle
    always @(negedge clk) begin
        enh.push_back(m_en);
        if (m_en) begin
            cap.push_back(m_txd);
            last_en_cyc <= cyc;
        end
        if (m_er) begin
            er_n <= er_n + 1;
            if (!(m_en && m_txd == 8'h00)) er_bad <= er_bad + 1;
        end
        if (m_sent) begin
            sent_n   <= sent_n + 1;
            sent_cyc <= cyc;
            len_at   <= m_flen;
        end
        if (m_err) begin
            err_n  <= err_n + 1;
            len_at <= m_flen;
        end
        if (m_rdy && !m_en) rdy_idle <= rdy_idle + 1;
    end

    task automatic mon_clear();
        cap.delete();
        enh.delete();
        sent_n = 0; err_n = 0; er_n = 0; er_bad = 0; rdy_idle = 0;
        last_en_cyc = -1; sent_cyc = -1; len_at = '0;
    endtask

    // Reference model: whole-frame byte list built from the framing rules
    logic [31:0] crc_tab [256];
    logic [7:0]  pay[$];
    int          lens[$];
    logic [7:0]  exp_q[$];

    function automatic logic [31:0] ref_fcs(input logic [7:0] body[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (body[i]) c = (c >> 8) ^ crc_tab[(c[7:0] ^ body[i])];
        return ~c;
    endfunction

    function automatic void build_exp(input int base, input int n, input int minf, input bit crc);
        logic [7:0]  body[$];
        logic [31:0] f;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) body.push_back(pay[base + i]);
        while (body.size() < minf) body.push_back(8'h00);
        foreach (body[i]) exp_q.push_back(body[i]);
        if (crc) begin
            f = ref_fcs(body);
            for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
        end
    endfunction

    function automatic logic [7:0] cap_at(input int i);
        if (i >= 0 && i < cap.size()) return cap[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        if (i >= 0 && i < exp_q.size()) return exp_q[i];
        return 8'hxx;
    endfunction

    function automatic int frame_diff();
        int n = (cap.size() > exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap_at(i) !== exp_at(i)) return i;
        return -1;
    endfunction

    // tx_en=0 cycles between the first and second bursts of tx_en=1
    function automatic int gap_len();
        int i = 0;
        int z = 0;
        while (i < enh.size() && !enh[i]) i++;
        while (i < enh.size() && enh[i]) i++;
        while (i < enh.size() && !enh[i]) begin z++; i++; end
        if (i >= enh.size()) return -1;
        return z;
    endfunction

    function automatic void new_payload(input int n);
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endfunction

    // Streams all frames in lens[] from pay[], keeping valid high between frames.
    // ua > 0 drops valid after ua accepted bytes.
    task automatic drive(input int ua, output bit ok);
        int f = 0, idx = 0, base = 0, acc_n = 0, t = 0;
        bit acc;
        ok = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b1;
        drv_data  = pay[0];
        drv_last  = (lens[0] == 1);
        while (1) begin
            @(negedge clk);
            acc = drv_valid && m_rdy;
            @(posedge clk); #1;
            t++;
            if (acc) begin
                acc_n++;
                idx++;
                if (idx == lens[f]) begin
                    base += lens[f];
                    f++;
                    idx = 0;
                    if (f == lens.size()) break;
                end
                if (ua != 0 && acc_n == ua) break;
                drv_data = pay[base + idx];
                drv_last = (idx == lens[f] - 1);
            end
            if (t > 3000) begin ok = 1'b0; break; end
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_data  = 8'h00;
    endtask

    task automatic wait_done(input int want, output bit ok);
        int t = 0;
        ok = 1'b1;
        while (sent_n + err_n < want) begin
            @(posedge clk);
            t++;
            if (t > 2000) begin ok = 1'b0; break; end
        end
        repeat (16) @(posedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        #20;
        n_tests++; if (m_txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h want 00", m_txd); end
        n_tests++; if (m_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", m_en); end
        n_tests++; if (m_er !== 1'b0) begin n_fail++; $display("FAIL reset_tx_er: got %b want 0", m_er); end
        n_tests++; if (m_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", m_rdy); end
        n_tests++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        n_tests++; if (m_sent !== 1'b0) begin n_fail++; $display("FAIL reset_sent: got %b want 0", m_sent); end
        n_tests++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", m_err); end
        n_tests++; if (m_flen !== 16'h0) begin n_fail++; $display("FAIL reset_length: got %h want 0", m_flen); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_crc_vector();
        bit ok1, ok2;
        int bad;
        logic [31:0] got_fcs;
        sel = 1;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        lens.push_back(9);
        build_exp(0, 9, 0, 1'b1);
        drive(0, ok1);
        wait_done(1, ok2);
        n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL crcvec_timeout: drive %b done %b want 1 1", ok1, ok2); end
        bad = frame_diff();
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL crcvec_frame: byte %0d got %h want %h (%0d/%0d bytes)", bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size());
        end
        got_fcs = {cap_at(cap.size() - 1), cap_at(cap.size() - 2), cap_at(cap.size() - 3), cap_at(cap.size() - 4)};
        n_tests++; if (got_fcs !== 32'hCBF43926) begin n_fail++; $display("FAIL crcvec_fcs: got %h want cbf43926", got_fcs); end
        n_tests++; if (cap.size() != 21) begin n_fail++; $display("FAIL crcvec_en_cycles: got %0d want 21", cap.size()); end
        n_tests++; if (sent_n != 1) begin n_fail++; $display("FAIL crcvec_sent_count: got %0d want 1", sent_n); end
        n_tests++; if (len_at !== 16'd9) begin n_fail++; $display("FAIL crcvec_length: got %0d want 9", len_at); end
        n_tests++; if (sent_cyc != last_en_cyc + 1) begin n_fail++; $display("FAIL crcvec_sent_timing: got %0d want %0d", sent_cyc, last_en_cyc + 1); end
    endtask

    task automatic test_padding();
        bit ok1, ok2;
        int bad;
        sel = 0;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        new_payload(14);
        lens.push_back(14);
        build_exp(0, 14, 60, 1'b1);
        drive(0, ok1);
        wait_done(1, ok2);
        n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL pad_timeout: drive %b done %b want 1 1", ok1, ok2); end
        bad = frame_diff();
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL pad_frame: byte %0d got %h want %h (%0d/%0d bytes)", bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size());
        end
        n_tests++; if (cap.size() != 72) begin n_fail++; $display("FAIL pad_en_cycles: got %0d want 72", cap.size()); end
        n_tests++; if (len_at !== 16'd14) begin n_fail++; $display("FAIL pad_length: got %0d want 14", len_at); end
        n_tests++; if (err_n != 0) begin n_fail++; $display("FAIL pad_error_pulses: got %0d want 0", err_n); end
    endtask

    task automatic test_random_frames();
        int lset[5];
        bit ok1, ok2;
        int bad;
        sel = 0;
        lset = '{1, 59, 60, 61, 0};
        lset[4] = $urandom_range(2, 120);
        for (int k = 0; k < 5; k++) begin
            mon_clear();
            pay.delete(); lens.delete(); exp_q.delete();
            new_payload(lset[k]);
            lens.push_back(lset[k]);
            build_exp(0, lset[k], 60, 1'b1);
            drive(0, ok1);
            wait_done(1, ok2);
            bad = frame_diff();
            n_tests++;
            if (!(ok1 && ok2) || bad >= 0) begin
                n_fail++;
                $display("FAIL rand_frame len %0d: byte %0d got %h want %h (%0d/%0d bytes, done %b%b)",
                         lset[k], bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size(), ok1, ok2);
            end
            n_tests++;
            if (len_at !== 16'(lset[k])) begin
                n_fail++;
                $display("FAIL rand_length: got %0d want %0d", len_at, lset[k]);
            end
            n_tests++;
            if (sent_cyc != last_en_cyc + 1 || sent_n != 1) begin
                n_fail++;
                $display("FAIL rand_sent: got cycle %0d count %0d want cycle %0d count 1", sent_cyc, sent_n, last_en_cyc + 1);
            end
        end
    endtask

    task automatic test_underrun();
        bit ok1, ok2, ok3;
        int bad, g;
        sel = 0;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        new_payload(40);
        lens.push_back(40);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(pay[i]);
        exp_q.push_back(8'h00);
        drive(20, ok1);
        // Follow-up frame offered immediately; valid during the gap must be ignored
        pay.delete(); lens.delete();
        new_payload(8);
        lens.push_back(8);
        build_exp(0, 8, 60, 1'b1);
        drive(0, ok2);
        wait_done(2, ok3);
        n_tests++; if (!(ok1 && ok2 && ok3)) begin n_fail++; $display("FAIL underrun_timeout: %b%b%b want 111", ok1, ok2, ok3); end
        bad = frame_diff();
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL underrun_frames: byte %0d got %h want %h (%0d/%0d bytes)", bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size());
        end
        n_tests++; if (er_n != 1 || er_bad != 0) begin n_fail++; $display("FAIL underrun_tx_er: got %0d cycles (%0d bad) want 1 (0 bad)", er_n, er_bad); end
        n_tests++; if (err_n != 1) begin n_fail++; $display("FAIL underrun_error_pulses: got %0d want 1", err_n); end
        n_tests++; if (sent_n != 1) begin n_fail++; $display("FAIL underrun_sent_pulses: got %0d want 1", sent_n); end
        g = gap_len();
        n_tests++; if (g != 12) begin n_fail++; $display("FAIL underrun_gap: got %0d want 12", g); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int bad, g;
        sel = 0;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        new_payload(128);
        lens.push_back(64);
        lens.push_back(64);
        build_exp(0, 64, 60, 1'b1);
        build_exp(64, 64, 60, 1'b1);
        drive(0, ok1);
        wait_done(2, ok2);
        n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_timeout: drive %b done %b want 1 1", ok1, ok2); end
        bad = frame_diff();
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL b2b_frames: byte %0d got %h want %h (%0d/%0d bytes)", bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size());
        end
        g = gap_len();
        n_tests++; if (g != 12) begin n_fail++; $display("FAIL b2b_gap: got %0d want 12", g); end
        n_tests++; if (rdy_idle != 0) begin n_fail++; $display("FAIL b2b_ready_in_gap: got %0d cycles want 0", rdy_idle); end
        n_tests++; if (sent_n != 2 || len_at !== 16'd64) begin n_fail++; $display("FAIL b2b_sent: got %0d pulses len %0d want 2 pulses len 64", sent_n, len_at); end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2;
        int bad;
        sel = 0;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        new_payload(4);
        @(posedge clk); #1;
        drv_valid = 1'b1;
        drv_data  = pay[0];
        drv_last  = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        n_tests++; if (m_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_frame: tx_en got %b want 1", m_en); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (m_txd !== 8'h00 || m_en !== 1'b0 || m_busy !== 1'b0 || m_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: txd %h en %b busy %b ready %b want 00 0 0 0", m_txd, m_en, m_busy, m_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        new_payload(10);
        lens.push_back(10);
        build_exp(0, 10, 60, 1'b1);
        drive(0, ok1);
        wait_done(1, ok2);
        bad = frame_diff();
        n_tests++;
        if (!(ok1 && ok2) || bad >= 0) begin
            n_fail++;
            $display("FAIL rstmid_fresh_frame: byte %0d got %h want %h (%0d/%0d bytes, done %b%b)",
                     bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size(), ok1, ok2);
        end
        n_tests++; if (sent_n != 1 || err_n != 0) begin n_fail++; $display("FAIL rstmid_pulses: sent %0d err %0d want 1 0", sent_n, err_n); end
    endtask

    task automatic test_no_crc();
        bit ok1, ok2;
        int bad;
        sel = 2;
        mon_clear();
        pay.delete(); lens.delete(); exp_q.delete();
        new_payload(60);
        lens.push_back(60);
        build_exp(0, 60, 60, 1'b0);
        drive(0, ok1);
        wait_done(1, ok2);
        n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL nocrc_timeout: drive %b done %b want 1 1", ok1, ok2); end
        bad = frame_diff();
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL nocrc_frame: byte %0d got %h want %h (%0d/%0d bytes)", bad, cap_at(bad), exp_at(bad), cap.size(), exp_q.size());
        end
        n_tests++; if (cap.size() != 68) begin n_fail++; $display("FAIL nocrc_en_cycles: got %0d want 68", cap.size()); end
        n_tests++; if (sent_cyc != last_en_cyc + 1 || sent_n != 1) begin n_fail++; $display("FAIL nocrc_sent: got cycle %0d count %0d want cycle %0d count 1", sent_cyc, sent_n, last_en_cyc + 1); end
        n_tests++; if (len_at !== 16'd60) begin n_fail++; $display("FAIL nocrc_length: got %0d want 60", len_at); end
    endtask

    initial begin
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        rst_n     = 1'b0;
        drv_data  = 8'h00;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        sel       = 0;
        mon_clear();
        test_reset();
        test_crc_vector();
        test_padding();
        test_random_frames();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_no_crc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ethernet_transmitter.md
Name: ethernet_transmitter

Overview:
GMII-side Ethernet MAC transmit framer, the transmit counterpart of ethernet_receiver, in the 125 MHz Ethernet clock domain. It accepts payload bytes (destination MAC through end of payload) over a valid/ready/last byte stream. It emits a complete GMII frame: preamble, SFD, payload, zero padding to minimum length, CRC-32 FCS, then enforced inter-frame gap. The bench and loopback tests drive ethernet_receiver directly from its txd/tx_en.

Parameters:
DATA_WIDTH, 8, GMII byte width; only 8 is supported.
ENABLE_CRC, 1, 1 = append 4-byte FCS; 0 = omit FCS state entirely.
MIN_FRAME, 60, minimum bytes before FCS; shorter payloads are zero-padded; 0 disables padding.
IFG_BYTES, 12, idle cycles forced after each frame (tx_en=0).

Ports:
clk  input  1  125 MHz GMII transmit clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
tx_data  input  DATA_WIDTH  payload byte.
tx_data_valid  input  1  tx_data valid.
tx_data_last  input  1  qualifies the final payload byte of the frame.
tx_data_ready  output  1  byte accepted when valid & ready.
txd  output  DATA_WIDTH  GMII transmit data (registered).
tx_en  output  1  GMII transmit enable (registered).
tx_er  output  1  GMII transmit error (registered).
tx_busy  output  1  high in any state other than IDLE.
frame_sent  output  1  one-cycle pulse on the cycle after the last FCS/pad/data byte leaves txd, for good frames.
frame_error  output  1  one-cycle pulse on underrun abort.
frame_length  output  16  payload bytes accepted in the last frame, excluding pad and FCS; saturates at 0xFFFF; valid when frame_sent or frame_error pulses.

Behaviour:
- Reset (asynchronous, immediate, even mid-frame): state=IDLE; txd=0x00, tx_en=0, tx_er=0, tx_data_ready=0, tx_busy=0, frame_sent=0, frame_error=0, frame_length=0; CRC=0xFFFFFFFF; counters=0. No partial frame resumes after release.
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE: when tx_data_valid=1 at edge N, go to PREAMBLE. txd=0x55 with tx_en=1 for cycles N+1..N+7.
- SFD: txd=0xD5 at N+8. tx_data_ready=1 during the SFD cycle and during DATA until the last byte is accepted. It is combinational from state and the last flag.
- DATA: a byte accepted at edge k appears on txd at k+1. The first payload byte is on txd at N+9.
- Each accepted byte updates the CRC and increments the byte counter.
- Accepting a byte with tx_data_last=1 drops ready. Next state: PAD if count < MIN_FRAME; else FCS (ENABLE_CRC=1) or IFG.
- Underrun: in DATA, tx_data_valid=0 before last is accepted causes:
  - txd=0x00, tx_en=1, tx_er=1 for one cycle;
  - frame_error pulse;
  - then IFG.
  - No FCS is sent and frame_sent does not pulse.
- PAD: txd=0x00, tx_en=1, included in CRC, until total count = MIN_FRAME; then FCS or IFG.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB-first. FCS = ~CRC, sent as 4 bytes, least-significant byte first.
- IFG: tx_en=0, txd=0x00 for exactly IFG_BYTES cycles, then IDLE. tx_data_valid held during IFG is ignored.
- Back-to-back frames: the next preamble starts IFG_BYTES+1 cycles after the last tx_en=1 cycle (IFG plus the IDLE sampling cycle).
- Byte counter is 16-bit and saturating; it never wraps. CRC and counter reset on IDLE exit.
- tx_data_last without tx_data_valid is ignored. tx_data_last=1 on the very first byte produces a 1-byte payload, padded to MIN_FRAME.

Test Plan:
- MIN_FRAME=0, ENABLE_CRC=1, payload ASCII "123456789" (0x31..0x39), last on 0x39 -> txd sequence 7×0x55, 0xD5, 0x31..0x39, 0x26, 0x39, 0xF4, 0xCB. tx_en high for exactly 21 cycles. frame_sent pulses once. frame_length=9.
- Default params, 14-byte payload -> 46 pad bytes of 0x00. tx_en high 8+60+4=72 cycles. frame_length=14. FCS matches the reference model over 60 bytes. ethernet_receiver in loopback reports frame_valid=1, frame_error=0.
- Underrun: drop tx_data_valid after 20 bytes -> one cycle with tx_er=1, tx_en=1, txd=0x00. frame_error pulses, no FCS bytes, then 12 cycles tx_en=0.
- Back-to-back: valid held continuously across two 64-byte frames -> exactly 12 tx_en=0 cycles between frames. ready low throughout IFG. Both frames' FCS are correct.
- Assert rst_n low mid-DATA -> txd=0, tx_en=0, tx_busy=0 immediately with no clock edge. After release with valid=1, a fresh 7×0x55 preamble is produced.
- ENABLE_CRC=0, 60-byte payload -> tx_en high exactly 68 cycles, no FCS, frame_sent pulses on the cycle after the last data byte.
